// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode 7-segment driver with shadowed value,
// per-digit enable/dp, optional leading-zero blanking and dead time.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 0,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2(CLK_DIV)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              Seg,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   An,
  output logic [IW-1:0]           scan_idx
);

  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;

  logic [3:0]            nib;
  logic                  lz;
  logic                  vis;
  logic                  wrap;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign wrap = (cnt == CW'(CLK_DIV - 1));

  always_comb begin
    nib = sh_value[4*int'(scan_idx) +: 4];
    lz  = 1'b0;
    // blank when this and every more-significant nibble is zero
    if (LZ_BLANK != 0 && scan_idx != '0) begin
      lz = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (j >= int'(scan_idx) && sh_value[4*j +: 4] != 4'h0)
          lz = 1'b0;
      end
    end
    vis   = (cnt >= CW'(BLANK_CYCLES)) && sh_en[scan_idx] && !lz;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    if (vis) begin
      seg_d          = glyph(nib);
      dp_d           = ~sh_dp[scan_idx];
      an_d[scan_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      scan_idx <= '0;
      sh_value <= '0;
      sh_dp    <= '0;
      sh_en    <= '0;
      Seg      <= 7'h7F;
      DP       <= 1'b1;
      An       <= '1;
    end else begin
      if (wrap) begin
        cnt <= '0;
        if (scan_idx == IW'(NUM_DIGITS - 1))
          scan_idx <= '0;
        else
          scan_idx <= scan_idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp;
        sh_en    <= digit_en;
      end
      Seg <= seg_d;
      DP  <= dp_d;
      An  <= an_d;
    end
  end

endmodule
